// File: rtl/mem_arb_pkg.sv
// Shared types and parameter-range checks for the fetch/load-store memory arbiter.
// The range checks are used by the RTL at elaboration and by the testbench.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_e;

  function automatic bit max_consec_ok(input int v);
    return v >= 1;
  endfunction

  function automatic bit timeout_ok(input int v);
    return v >= 0;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Access watchdog: counts ISSUE cycles without an ack and flags the terminal count.
// With TIMEOUT=0 the watchdog is absent and tc_o never fires.
module mem_arb_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  if (TIMEOUT == 0) begin : g_off
    logic unused_tie;
    assign unused_tie = ^{clk_i, rst_i, clr_i, en_i};
    assign tc_o       = 1'b0;
  end else begin : g_on
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
        cnt_d = '0;
      end else if (en_i) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    // Fires on the last permitted cycle so the abort edge lands after exactly TIMEOUT cycles.
    assign tc_o = (cnt_q == CW'(TIMEOUT - 1));
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the instruction-fetch port and the load/store port.
// One access at a time; data has priority but fetch is guaranteed a grant after MAX_CONSEC data grants.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_CONSEC = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_done,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_done,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W = DATA_W / 8;
  localparam int SW   = $clog2(MAX_CONSEC + 1);

  if (!max_consec_ok(MAX_CONSEC)) begin : g_bad_max_consec
    $error("mem_arbiter: MAX_CONSEC must be >= 1");
  end
  if (!timeout_ok(TIMEOUT)) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT must be >= 0");
  end

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic              err_q, err_d;

  logic tmr_tc;
  logic abort;
  logic any_req;
  logic fetch_wins;
  logic finish;

  mem_arb_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk_i(clk),
    .rst_i(reset),
    .clr_i(state_q == IDLE),
    .en_i (state_q == ISSUE && !mem_ack),
    .tc_o (tmr_tc)
  );

  // A same-cycle ack beats the timeout.
  assign abort      = tmr_tc & ~mem_ack;
  assign finish     = mem_ack | abort;
  assign any_req    = i_req | d_req;
  assign fetch_wins = ~d_req | (starve_q == SW'(MAX_CONSEC));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   if (finish)  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d     = owner_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!i_req) starve_d = '0;
        if (any_req) begin
          mem_req_d = 1'b1;
          if (fetch_wins) begin
            owner_d    = OWN_I;
            starve_d   = '0;
            mem_we_d   = 1'b0;
            mem_addr_d = i_addr;
            mem_be_d   = '1;
          end else begin
            owner_d     = OWN_D;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_be_d    = d_be;
            if (i_req && starve_q != SW'(MAX_CONSEC)) starve_d = starve_q + 1'b1;
          end
        end
      end
      ISSUE: begin
        if (finish) begin
          mem_req_d = 1'b0;
          err_d     = abort;
          if (owner_q == OWN_I) begin
            i_done_d  = 1'b1;
            i_rdata_d = mem_ack ? mem_rdata : '0;
          end else begin
            d_done_d  = 1'b1;
            d_rdata_d = mem_ack ? mem_rdata : '0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q     <= OWN_I;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level reference model checked every cycle,
// plus hand-computed expectations for latency, grant order, timeout and reset.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXC = 4;
  localparam int TMO  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_done;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [BW-1:0] d_be = '0;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  logic          err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_CONSEC(MAXC), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_done(d_done), .d_rdata(d_rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Memory: acks after ack_wait idle cycles of mem_req (1000 = never).
  int ack_wait = 0;
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == 32'h10) return 32'h0050_0093;
    return ~a ^ 32'h1357_9BDF;
  endfunction

  initial begin : memory
    int mwait;
    mwait = 0;
    forever begin
      @(negedge clk);
      #1;
      if (mem_req && !reset) begin
        mem_ack   = (mwait == ack_wait);
        mem_rdata = mem_word(mem_addr);
        mwait++;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'hBAD0_BAD0;
        mwait     = 0;
      end
    end
  end

  // Monitor data read by the directed tests.
  int            last_req_len = 0;
  int            n_idone = 0;
  int            n_ddone = 0;
  int            n_grants = 0;
  logic [15:0]   glog = '0;

  // Reference model: one access in flight, then one response cycle, then idle.
  initial begin : cmp
    bit            m_busy, m_resp, m_own_i;
    int            m_wait, m_consec, cur_len;
    bit            prev_req, i_pend, fw;
    logic          e_mem_req, e_mem_we, e_i_done, e_d_done, e_err;
    logic [AW-1:0] e_mem_addr;
    logic [DW-1:0] e_mem_wdata, e_i_rdata, e_d_rdata, v;
    logic [BW-1:0] e_mem_be;
    prev_req = 0; cur_len = 0; i_pend = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_busy = 0; m_resp = 0; m_own_i = 0; m_wait = 0; m_consec = 0;
        e_mem_req = 0; e_mem_we = 0; e_i_done = 0; e_d_done = 0; e_err = 0;
        e_mem_addr = '0; e_mem_wdata = '0; e_i_rdata = '0; e_d_rdata = '0; e_mem_be = '0;
        i_pend = 0;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_dones", {i_done, d_done, err}, 0);
        chk("rst_rdata", {i_rdata, d_rdata}, 0);
        chk("rst_mem_bus", {mem_we, mem_addr, mem_be}, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
      end else begin
        chk("mem_req", mem_req, e_mem_req);
        chk("i_done", i_done, e_i_done);
        chk("d_done", d_done, e_d_done);
        chk("err", err, e_err);
        chk("i_rdata", i_rdata, e_i_rdata);
        chk("d_rdata", d_rdata, e_d_rdata);
        if (e_mem_req) begin
          chk("mem_we", mem_we, e_mem_we);
          chk("mem_addr", mem_addr, e_mem_addr);
          chk("mem_be", mem_be, e_mem_be);
          if (e_mem_we) chk("mem_wdata", mem_wdata, e_mem_wdata);
        end
        assert (!(i_pend && !i_req)) else $error("protocol: i_req dropped before i_done");
        if (i_done) i_pend = 0;
        else if (i_req) i_pend = 1;
      end
      if (mem_req && !prev_req) begin
        n_grants++;
        glog = {glog[14:0], mem_addr[13:12] == 2'b01};
        cur_len = 1;
      end else if (mem_req) begin
        cur_len++;
      end else if (prev_req) begin
        last_req_len = cur_len;
      end
      prev_req = mem_req;
      if (i_done) n_idone++;
      if (d_done) n_ddone++;
      #2;
      if (!reset) begin
        if (m_resp) begin
          m_resp = 0; e_i_done = 0; e_d_done = 0; e_err = 0;
        end else if (m_busy) begin
          if (mem_ack || m_wait == TMO - 1) begin
            v = mem_ack ? mem_rdata : '0;
            if (m_own_i) begin e_i_rdata = v; e_i_done = 1; end
            else begin e_d_rdata = v; e_d_done = 1; end
            e_err = !mem_ack; e_mem_req = 0; m_busy = 0; m_resp = 1;
          end else begin
            m_wait++;
          end
        end else begin
          if (!i_req) m_consec = 0;
          if (i_req || d_req) begin
            fw = !d_req || (m_consec == MAXC);
            if (fw) begin
              m_own_i = 1; m_consec = 0;
              e_mem_we = 0; e_mem_addr = i_addr; e_mem_be = '1;
            end else begin
              m_own_i = 0;
              if (i_req && m_consec < MAXC) m_consec++;
              e_mem_we = d_we; e_mem_addr = d_addr; e_mem_wdata = d_wdata; e_mem_be = d_be;
            end
            m_busy = 1; m_wait = 0; e_mem_req = 1;
          end
        end
      end
    end
  end

  task automatic wait_done(input bit is_i, input string name, output int at_cyc, output logic at_err);
    bit seen;
    seen = 0; at_cyc = -1; at_err = 1'bx;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (is_i ? i_done : d_done) begin
        seen = 1; at_cyc = cyc; at_err = err;
      end
    end
    checks++;
    if (!seen) begin
      fails++;
      $display("FAIL %s: done not seen within 100 cycles", name);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [AW-1:0] a, input string name, output int at_cyc, output logic at_err);
    i_req = 1; i_addr = a;
    wait_done(1, name, at_cyc, at_err);
    i_req = 0;
  endtask

  task automatic data(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input logic [BW-1:0] be, input string name, output int at_cyc, output logic at_err);
    d_req = 1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
    wait_done(0, name, at_cyc, at_err);
    d_req = 0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int   c0, dc, n0;
    logic e;
    if (!max_consec_ok(MAXC) || !timeout_ok(TMO)) begin
      $display("FAIL params: bench parameters out of range");
      $fatal(1, "params");
    end
    #1 reset = 1;
    repeat (3) @(posedge clk);
    chk("reset_mem_req", mem_req, 0);
    chk("reset_rdata", i_rdata, 0);
    #3 reset = 0;
    @(posedge clk); #1;

    // 1: fetch, ack in first mem_req cycle
    ack_wait = 0;
    c0 = cyc;
    fetch(32'h10, "t1_done", dc, e);
    chk("t1_latency", dc - c0, 2);
    chk("t1_rdata", i_rdata, 32'h0050_0093);
    chk("t1_err", e, 0);
    chk("t1_req_len", last_req_len, 1);

    // 2: store with three wait cycles
    ack_wait = 3;
    n0 = n_idone;
    data(1, 32'h200, 32'hDEAD_BEEF, 4'b0011, "t2_done", dc, e);
    chk("t2_req_len", last_req_len, 4);
    chk("t2_no_idone", n_idone - n0, 0);
    chk("t2_bus", {mem_we, mem_addr, mem_be}, {1'b1, 32'h200, 4'b0011});
    chk("t2_wdata", mem_wdata, 32'hDEAD_BEEF);

    // 3: both ports saturated
    ack_wait = 1;
    n0 = n_grants;
    fork
      begin
        for (int k = 0; k < 8; k++) data(0, 32'h2000 + 32'(4 * k), '0, 4'hF, "t3_d", dc, e);
      end
      begin
        for (int k = 0; k < 2; k++) fetch(32'h1000 + 32'(4 * k), "t3_i", dc, e);
      end
    join
    chk("t3_grants", n_grants - n0, 10);
    chk("t3_order", glog[9:0], 10'b00001_00001);

    // 4: memory never acks, then a normal access
    ack_wait = 1000;
    data(0, 32'h300, '0, 4'hF, "t4_done", dc, e);
    chk("t4_req_len", last_req_len, 8);
    chk("t4_err", e, 1);
    chk("t4_rdata", d_rdata, 0);
    ack_wait = 2;
    data(0, 32'h304, '0, 4'hF, "t4_next", dc, e);
    chk("t4_next_err", e, 0);
    chk("t4_next_rdata", d_rdata, mem_word(32'h304));

    // 6: ack on the cycle the timeout would fire
    ack_wait = 7;
    fetch(32'h1010, "t6_done", dc, e);
    chk("t6_err", e, 0);
    chk("t6_req_len", last_req_len, 8);
    chk("t6_rdata", i_rdata, mem_word(32'h1010));

    // 5: reset in the middle of ISSUE
    ack_wait = 1000;
    i_req = 1; i_addr = 32'h1020;
    repeat (3) @(posedge clk);
    #3;
    chk("t5_issuing", mem_req, 1);
    reset = 1;
    #1;
    chk("t5_mem_req", mem_req, 0);
    chk("t5_done", {i_done, d_done, err}, 0);
    i_req = 0;
    n0 = n_idone;
    repeat (2) @(posedge clk);
    #3 reset = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("t5_no_done", n_idone - n0, 0);
    chk("t5_idle", mem_req, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
